// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, write-allocate cache between the pipeline and a pipelined
// backing memory. Hits complete combinationally; misses stall while an 8-word line is fetched.
module dm_cache_ctrl #(
  parameter int INDEX_BITS      = 7,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_wr_i,
  input  logic [15:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic [15:0] rdata_o,
  output logic        stall_o,
  output logic        mem_en_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic [15:0] miss_count_o
);
  localparam int TAG_BITS = 16 - INDEX_BITS - 4;
  localparam int LINES    = 1 << INDEX_BITS;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [3:0]            issue_cnt_q, issue_cnt_d;
  logic [2:0]            ret_cnt_q, ret_cnt_d;
  logic [15:0]           miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   fill_tag_q;
  logic [INDEX_BITS-1:0] fill_idx_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [15:0]           data_q [LINES][WORDS_PER_BLOCK];

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_idx;
  logic [2:0]            req_off;
  logic                  unused_addr_lsb;

  assign req_tag         = req_addr_i[15:16-TAG_BITS];
  assign req_idx         = req_addr_i[INDEX_BITS+3:4];
  assign req_off         = req_addr_i[3:1];
  assign unused_addr_lsb = req_addr_i[0];

  logic hit, idle, in_fill, rd_hit, wr_hit, miss, fill_issue, fill_ret, fill_done;

  // Everything is gated by rst_i so outputs stay quiet while reset is held.
  assign idle       = (state_q == S_IDLE) & ~rst_i;
  assign in_fill    = (state_q == S_FILL) & ~rst_i;
  assign hit        = req_valid_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign rd_hit     = idle & hit & ~req_wr_i;
  assign wr_hit     = idle & hit & req_wr_i;
  assign miss       = idle & req_valid_i & ~hit;
  assign fill_issue = in_fill & ~issue_cnt_q[3];
  assign fill_ret   = in_fill & mem_rvalid_i;
  assign fill_done  = fill_ret & (ret_cnt_q == 3'd7);

  assign stall_o      = miss | in_fill;
  assign rdata_o      = rd_hit ? data_q[req_idx][req_off] : 16'h0000;
  assign mem_en_o     = wr_hit | fill_issue;
  assign mem_wr_o     = wr_hit;
  assign mem_wdata_o  = wr_hit ? req_wdata_i : 16'h0000;
  assign miss_count_o = miss_cnt_q;

  // Fill base has a zero offset field, so base + 2*n is just the count in bits [3:1].
  always_comb begin
    mem_addr_o = 16'h0000;
    if (wr_hit)          mem_addr_o = {req_addr_i[15:1], 1'b0};
    else if (fill_issue) mem_addr_o = {fill_tag_q, fill_idx_q, issue_cnt_q[2:0], 1'b0};
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (miss) begin
      state_d     = S_FILL;
      issue_cnt_d = 4'd0;
      ret_cnt_d   = 3'd0;
      if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    end
    if (fill_issue) issue_cnt_d = issue_cnt_q + 4'd1;
    if (fill_ret)   ret_cnt_d   = ret_cnt_q + 3'd1;
    if (fill_done)  state_d     = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= 4'd0;
      ret_cnt_q   <= 3'd0;
      miss_cnt_q  <= 16'h0000;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      if (fill_done) valid_q[fill_idx_q] <= 1'b1;
    end
  end

  // Line storage and the fill target are not reset; valid_q alone guards them.
  always_ff @(posedge clk_i) begin
    if (miss) begin
      fill_tag_q <= req_tag;
      fill_idx_q <= req_idx;
    end
    if (wr_hit)    data_q[req_idx][req_off]      <= req_wdata_i;
    if (fill_ret)  data_q[fill_idx_q][ret_cnt_q] <= mem_rdata_i;
    if (fill_done) tag_q[fill_idx_q]             <= fill_tag_q;
  end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: pipelined memory model plus a scoreboard of expected request results.
module tb_dm_cache_ctrl;
  localparam int MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata, miss_count;
  logic        stall, mem_en, mem_wr, mem_rvalid;

  dm_cache_ctrl #(.INDEX_BITS(7), .WORDS_PER_BLOCK(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rdata_o(rdata), .stall_o(stall),
    .mem_en_o(mem_en), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid), .miss_count_o(miss_count)
  );

  always #5 clk = ~clk;

  // Backing memory: word at byte 2k holds 16'h1000 + k; reads return MEM_LAT cycles after issue.
  logic [15:0]        mem [32768];
  logic [MEM_LAT-1:0] lv = '0;
  logic [15:0]        ld [MEM_LAT];
  assign mem_rvalid = lv[MEM_LAT-1];
  assign mem_rdata  = ld[MEM_LAT-1];

  initial for (int k = 0; k < 32768; k++) mem[k] = 16'h1000 + 16'(k);

  always @(posedge clk) begin
    lv    <= {lv[MEM_LAT-2:0], mem_en & ~mem_wr};
    ld[0] <= mem[mem_addr[15:1]];
    for (int i = 1; i < MEM_LAT; i++) ld[i] <= ld[i-1];
    if (mem_en && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          stalls;
    logic [15:0] mcnt;
  } exp_t;
  exp_t sbq[$];

  // Reference cache state and expected memory image.
  logic        cval [128];
  logic [4:0]  ctag [128];
  logic [15:0] gold [32768];
  logic [15:0] mc;

  task automatic model_reset();
    for (int i = 0; i < 128; i++) cval[i] = 1'b0;
    mc = 16'h0000;
  endtask

  task automatic do_req(input logic wr, input logic [15:0] a, input logic [15:0] wd);
    logic [6:0]  idx;
    logic [4:0]  tg;
    logic        m;
    logic [15:0] base, ea;
    int          n, iss;
    exp_t        e;
    idx = a[10:4];
    tg  = a[15:11];
    m   = !(cval[idx] && ctag[idx] == tg);
    if (m) begin
      if (mc != 16'hFFFF) mc = mc + 16'd1;
      cval[idx] = 1'b1;
      ctag[idx] = tg;
    end
    if (wr) gold[a[15:1]] = wd;
    e.wr = wr; e.addr = {a[15:1], 1'b0}; e.wdata = wd; e.rdata = gold[a[15:1]];
    e.stalls = m ? 9 + MEM_LAT : 0; e.mcnt = mc;
    sbq.push_back(e);

    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
    base = {a[15:4], 4'b0000};
    n = 0; iss = 0;
    @(negedge clk);
    while (stall && n < 64) begin
      if (mem_en) begin
        ea = base + 16'(2 * iss);
        chk("fill_wr", {31'd0, mem_wr}, 32'd0);
        chk("fill_addr", {16'd0, mem_addr}, {16'd0, ea});
        iss++;
      end
      n++;
      @(negedge clk);
    end
    e = sbq.pop_front();
    chk("stall_cycles", n, e.stalls);
    chk("fill_reads", iss, (e.stalls != 0) ? 8 : 0);
    chk("done_mem_en", {31'd0, mem_en}, {31'd0, e.wr});
    chk("done_mem_wr", {31'd0, mem_wr}, {31'd0, e.wr});
    if (e.wr) begin
      chk("wt_addr", {16'd0, mem_addr}, {16'd0, e.addr});
      chk("wt_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
    end else begin
      chk("rdata", {16'd0, rdata}, {16'd0, e.rdata});
    end
    chk("miss_count", {16'd0, miss_count}, {16'd0, e.mcnt});
    @(posedge clk); #1;
    req_valid = 1'b0; req_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bad;
    for (int k = 0; k < 32768; k++) gold[k] = 16'h1000 + 16'(k);
    model_reset();

    // Reset held with a request present: everything quiet.
    req_valid = 1'b1; req_addr = 16'h0040;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_miss_count", {16'd0, miss_count}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("idle_stall", {31'd0, stall}, 32'd0);

    do_req(1'b0, 16'h0040, 16'h0000);   // cold miss -> 0x1020
    do_req(1'b0, 16'h004E, 16'h0000);   // same-line hit -> 0x1027
    do_req(1'b1, 16'h0042, 16'hBEEF);   // write hit, write-through
    do_req(1'b0, 16'h0042, 16'h0000);   // hit returns BEEF
    do_req(1'b0, 16'h0841, 16'h0000);   // conflict miss (odd byte addr) -> 0x1420
    do_req(1'b0, 16'h0040, 16'h0000);   // evicted line misses again
    do_req(1'b0, 16'h0042, 16'h0000);   // refetched line holds written-through BEEF
    do_req(1'b1, 16'h2000, 16'h1234);   // write miss, fill then write-through
    do_req(1'b0, 16'h2000, 16'h0000);   // reads back 0x1234
    do_req(1'b0, 16'h0048, 16'h0000);   // index 4 line still resident

    // Reset during the 5th fill cycle of a miss.
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0050;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("fill5_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("postrst_stall", {31'd0, stall}, 32'd0);
    chk("postrst_miss_count", {16'd0, miss_count}, 32'd0);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (stall || mem_en) bad = 1'b1;
    end
    chk("stray_rvalid_quiet", {31'd0, bad}, 32'd0);
    do_req(1'b0, 16'h0040, 16'h0000);   // full miss again after reset
    do_req(1'b0, 16'h0050, 16'h0000);   // aborted line was never installed

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Direct-mapped, write-through, write-allocate cache controller that sits between the pipeline's fetch stage or memory stage and a multi-cycle pipelined backing memory. It replaces a direct single-cycle memory1c hookup. Hits return read data combinationally in the request cycle. Misses assert stall while a fill FSM fetches an 8-word block and installs it.

Parameters:
MEM_LAT, 4, backing-memory read latency in cycles from issue to mem_rvalid (used only by the bench model; the controller counts mem_rvalid pulses).
INDEX_BITS, 7, number of index bits (128 lines).
WORDS_PER_BLOCK, 8, 16-bit words per line (fixed at 8; offset field is addr[3:1]).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  pipeline presents a memory request this cycle
req_wr  in  1  1 = store, 0 = load
req_addr  in  16  byte address; bit 0 ignored
req_wdata  in  16  store data
rdata  out  16  load data, valid when req_valid & ~req_wr & ~stall
stall  out  1  request not complete; pipeline must hold the request stable
mem_en  out  1  backing-memory access strobe
mem_wr  out  1  backing-memory write
mem_addr  out  16  backing-memory word address (byte address, bit 0 = 0)
mem_wdata  out  16  backing-memory write data
mem_rdata  in  16  backing-memory read data
mem_rvalid  in  1  mem_rdata valid (in-order returns)
miss_count  out  16  saturating count of misses since reset

Behaviour:
- Address split: tag = addr[15:11], index = addr[10:4], offset = addr[3:1].
- Storage: 128 lines, each with a valid bit, a 5-bit tag and 8 x 16-bit data words.
- hit = req_valid & valid[index] & (tag_array[index] == tag).
- Reset (rst high at an edge): all valid bits cleared, state = IDLE, fill counters = 0, miss_count = 0. Data and tag arrays are not cleared.
- Output values during reset and in IDLE with no request: stall = 0, mem_en = 0, mem_wr = 0, rdata = 0.
- States: IDLE, FILL.
- IDLE, read hit: rdata = line word[offset] combinationally; stall = 0; no memory access.
- IDLE, write hit: stall = 0; cache word[offset] <= req_wdata at the edge. Same cycle, write-through: mem_en = 1, mem_wr = 1, mem_addr = {req_addr[15:1], 0}, mem_wdata = req_wdata.
- IDLE, miss (read or write): stall = 1 combinationally; no memory write; miss_count += 1 (saturates at 16'hFFFF). Latch base = {tag, index, 4'b0}; next state FILL.
- FILL, issue: stall = 1. For issue_cnt = 0..7, one read per cycle: mem_en = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt. After 8 issues mem_en = 0.
- FILL, return: each mem_rvalid writes mem_rdata into word ret_cnt of line index; ret_cnt increments.
- FILL, completion: at the 8th mem_rvalid, tag_array[index] <= tag and valid[index] <= 1; next state IDLE.
- After the fill, the held request hits on the following cycle and completes as a normal hit. A write miss therefore performs its write-through at that point.
- Miss latency: stall is high for 9 + MEM_LAT cycles, counting from the miss-detect cycle (13 cycles at MEM_LAT = 4).
- mem_rvalid in IDLE is ignored.
- req_valid dropping during FILL: the fill still completes and the line is installed.
- A fill evicts the resident line unconditionally; no writeback is needed (write-through).
- rst asserted mid-FILL: next cycle state = IDLE, the partially filled line stays invalid, and stray mem_rvalid pulses are ignored.
- The request is sampled only in IDLE. The pipeline holds req_* stable while stall = 1.

Test Plan:
- Cold read: memory word at byte 2k = 16'h1000 + k; after rst, read 0x0040 -> stall high 13 cycles, mem reads 0x0040..0x004E issued on consecutive cycles, then rdata = 0x1020 with stall = 0; miss_count = 1.
- Hit in the same line: read 0x004E -> rdata = 0x1027 in the request cycle, stall = 0, mem_en = 0; miss_count stays 1.
- Write hit: write 0x0042 = 0xBEEF -> stall = 0, mem_en = mem_wr = 1, mem_addr = 0x0042, mem_wdata = 0xBEEF same cycle; a later read of 0x0042 returns 0xBEEF with no memory access.
- Conflict: read 0x0840 (index 4, tag 1) -> miss, returns 0x1420. Read 0x0040 -> miss again, miss_count increments each time.
- Write miss: write 0x2000 = 0x1234 -> 13-cycle fill of 0x2000..0x200E, then one cycle with mem_wr = 1 to 0x2000 and stall = 0; a later read of 0x2000 = 0x1234.
- Reset mid-fill: pulse rst on the 5th FILL cycle -> stall = 0 next cycle, late mem_rvalid ignored, read of 0x0040 misses again with a full 13-cycle stall.
